// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage between the synchronous instruction memory and the controller.
//   Reads are issued into a small prefetch queue (PC + instruction per entry).
//   The head entry is handed to the controller over a valid/ready handshake.
//   Prefetching stops once the halt word has been fetched.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   IM_Rd/IM_Addr       memory read strobe and address (data returns next cycle)
//   IM_Data             memory read data
//   IR_Valid/IR_Data/IR_PC/IR_Ready   queue head handshake to the controller
//   Redirect/Redirect_PC              branch/jump target load
//   FetchPC             address of the next read to issue
//   Halted              halt word has been consumed by the controller
module instr_fetch_unit #(
  parameter int unsigned           ADDR_W    = 7,
  parameter int unsigned           DATA_W    = 16,
  parameter int unsigned           DEPTH     = 2,
  parameter logic [DATA_W-1:0]     HALT_WORD = 16'h5000
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              IM_Rd,
  output logic [ADDR_W-1:0] IM_Addr,
  input  logic [DATA_W-1:0] IM_Data,
  output logic              IR_Valid,
  output logic [DATA_W-1:0] IR_Data,
  output logic [ADDR_W-1:0] IR_PC,
  input  logic              IR_Ready,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_PC,
  output logic [ADDR_W-1:0] FetchPC,
  output logic              Halted
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {FETCH, HALT_SEEN, HALTED} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pop, push, halt_push, issue;
  logic [CW:0]       occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign IR_Valid  = (count != '0);
  assign pop       = IR_Valid & IR_Ready;
  // A redirect kills the response arriving this cycle.
  assign push      = inflight & ~Redirect;
  assign halt_push = push & (IM_Data == HALT_WORD);

  // Occupancy the queue will reach once the outstanding read lands.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == FETCH) & ~Redirect & ~Reset & (occ < (CW+1)'(DEPTH));

  assign IM_Rd   = issue;
  assign IM_Addr = fetch_pc;
  assign FetchPC = fetch_pc;
  assign Halted  = (state == HALTED);
  assign IR_Data = IR_Valid ? q[head].data : '0;
  assign IR_PC   = IR_Valid ? q[head].pc   : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     if (halt_push) state_nxt = HALT_SEEN;
      // The halt word is always the last queued entry.
      HALT_SEEN: if (pop && q[head].data == HALT_WORD) state_nxt = HALTED;
      HALTED:    state_nxt = HALTED;
      default:   state_nxt = FETCH;
    endcase
    if (Redirect) state_nxt = FETCH;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= FETCH;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= '0;
    end else begin
      state       <= state_nxt;
      // A read issued alongside the arriving halt word is speculative: drop it.
      inflight    <= issue & ~halt_push;
      inflight_pc <= fetch_pc;
      if (issue) fetch_pc <= fetch_pc + 1'b1;
      if (Redirect) begin
        fetch_pc <= Redirect_PC;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge Clk) begin
    if (push && !Reset) q[tail] <= '{pc: inflight_pc, data: IM_Data};
  end

  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
    count <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge Clk) disable iff (Reset)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IM_Rd;
  logic [6:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic        IR_Valid;
  logic [15:0] IR_Data;
  logic [6:0]  IR_PC;
  logic        IR_Ready;
  logic        Redirect;
  logic [6:0]  Redirect_PC;
  logic [6:0]  FetchPC;
  logic        Halted;

  instr_fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .IM_Rd(IM_Rd), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .IR_Valid(IR_Valid), .IR_Data(IR_Data), .IR_PC(IR_PC), .IR_Ready(IR_Ready),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .FetchPC(FetchPC), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Synchronous instruction memory: data one cycle after the strobe.
  logic [15:0] mem [128];
  always @(posedge Clk) if (IM_Rd) IM_Data <= mem[IM_Addr];

  typedef struct { logic [6:0] pc; logic [15:0] data; } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [6:0] pc, input logic [15:0] data);
    exp_t e;
    e.pc = pc; e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every accepted head must be the next expected instruction.
  always @(negedge Clk) begin
    if (Reset === 1'b0 && IR_Valid === 1'b1 && IR_Ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop: got pc %0h data %0h expected none", IR_PC, IR_Data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", 32'(IR_PC), 32'(e.pc));
        chk("sb_data", 32'(IR_Data), 32'(e.data));
      end
    end
  end

  task automatic next_cycle();
    @(posedge Clk); #1;
  endtask

  // Leaves the bench in cycle 1 after Reset deasserts.
  task automatic do_reset();
    chk("sb_drained", 32'(sb.size()), 0);
    sb.delete();
    Reset = 1'b1; IR_Ready = 1'b0; Redirect = 1'b0;
    next_cycle();
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
    Reset = 1'b1; IR_Ready = 1'b0; Redirect = 1'b0; Redirect_PC = '0;
    next_cycle();
    @(negedge Clk);
    chk("rst_imrd", 32'(IM_Rd), 0);
    chk("rst_valid", 32'(IR_Valid), 0);
    chk("rst_data", 32'(IR_Data), 0);
    chk("rst_pc", 32'(IR_PC), 0);
    chk("rst_fetchpc", 32'(FetchPC), 0);
    chk("rst_halted", 32'(Halted), 0);

    // Straight-line fetch then backpressure.
    do_reset();
    for (int i = 0; i <= 13; i++) expect_pc(7'(i), 16'h1000 + 16'(i));
    IR_Ready = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c == 11) IR_Ready = 1'b0;
      if (c == 16) IR_Ready = 1'b1;
      if (c == 22) IR_Ready = 1'b0;
      @(negedge Clk);
      if (c == 1) begin
        chk("first_rd", 32'(IM_Rd), 1);
        chk("first_addr", 32'(IM_Addr), 0);
      end
      if (c == 2) chk("fill_valid_early", 32'(IR_Valid), 0);
      if (c >= 3 && c <= 10) begin
        chk("sl_valid", 32'(IR_Valid), 1);
        chk("sl_pc", 32'(IR_PC), 32'(c - 3));
      end
      if (c >= 11 && c <= 15) begin
        chk("bp_valid", 32'(IR_Valid), 1);
        chk("bp_pc", 32'(IR_PC), 8);
        chk("bp_data", 32'(IR_Data), 32'h1008);
        chk("bp_imrd", 32'(IM_Rd), 0);
      end
      next_cycle();
    end

    // Redirect while the read of PC 5 is in flight.
    do_reset();
    for (int i = 0; i <= 4; i++) expect_pc(7'(i), 16'h1000 + 16'(i));
    for (int i = 0; i <= 2; i++) expect_pc(7'h40 + 7'(i), 16'h1040 + 16'(i));
    IR_Ready = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      if (c == 7) begin Redirect = 1'b1; Redirect_PC = 7'h40; end
      if (c == 8) Redirect = 1'b0;
      if (c == 13) IR_Ready = 1'b0;
      @(negedge Clk);
      if (c == 7) chk("rd_no_issue", 32'(IM_Rd), 0);
      if (c == 8) begin
        chk("rd_imrd", 32'(IM_Rd), 1);
        chk("rd_addr", 32'(IM_Addr), 32'h40);
      end
      if (c == 8 || c == 9) chk("rd_gap", 32'(IR_Valid), 0);
      if (c == 10) begin
        chk("rd_valid", 32'(IR_Valid), 1);
        chk("rd_pc", 32'(IR_PC), 32'h40);
      end
      next_cycle();
    end

    // Wrap-around 7E -> 01.
    do_reset();
    expect_pc(7'h7E, 16'h107E); expect_pc(7'h7F, 16'h107F);
    expect_pc(7'h00, 16'h1000); expect_pc(7'h01, 16'h1001);
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin Redirect = 1'b1; Redirect_PC = 7'h7E; end
      if (c == 2) Redirect = 1'b0;
      if (c == 4) IR_Ready = 1'b1;
      if (c == 8) IR_Ready = 1'b0;
      @(negedge Clk);
      if (c == 2) chk("wr_addr", 32'(IM_Addr), 32'h7E);
      if (c >= 4 && c <= 7) chk("wr_pc", 32'(IR_PC), 32'((7'h7E + 7'(c - 4)) & 7'h7F));
      next_cycle();
    end

    // Halt word at PC 3, junk after it.
    mem[3] = 16'h5000; mem[4] = 16'hFFFF;
    do_reset();
    for (int i = 0; i <= 2; i++) expect_pc(7'(i), 16'h1000 + 16'(i));
    expect_pc(7'd3, 16'h5000);
    IR_Ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 13) begin IR_Ready = 1'b0; Redirect = 1'b1; Redirect_PC = 7'h10; end
      if (c == 14) Redirect = 1'b0;
      @(negedge Clk);
      if (c >= 6 && c <= 12) chk("ht_imrd", 32'(IM_Rd), 0);
      if (c == 6) chk("ht_halted_early", 32'(Halted), 0);
      if (c >= 7 && c <= 12) begin
        chk("ht_halted", 32'(Halted), 1);
        chk("ht_valid", 32'(IR_Valid), 0);
      end
      if (c == 14) begin
        chk("ht_clear", 32'(Halted), 0);
        chk("ht_restart_rd", 32'(IM_Rd), 1);
        chk("ht_restart_addr", 32'(IM_Addr), 32'h10);
      end
      next_cycle();
    end
    mem[3] = 16'h1003; mem[4] = 16'h1004;

    // Reset pulsed with a full queue.
    do_reset();
    expect_pc(7'd0, 16'h1000); expect_pc(7'd1, 16'h1001);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) Reset = 1'b1;
      if (c == 6) Reset = 1'b0;
      if (c == 8) IR_Ready = 1'b1;
      if (c == 10) IR_Ready = 1'b0;
      @(negedge Clk);
      if (c == 4) begin
        chk("mr_full_valid", 32'(IR_Valid), 1);
        chk("mr_full_pc", 32'(IR_PC), 0);
        chk("mr_full_imrd", 32'(IM_Rd), 0);
      end
      if (c == 6) begin
        chk("mr_valid", 32'(IR_Valid), 0);
        chk("mr_fetchpc", 32'(FetchPC), 0);
        chk("mr_imrd", 32'(IM_Rd), 1);
        chk("mr_addr", 32'(IM_Addr), 0);
      end
      if (c == 8) begin
        chk("mr_refill_valid", 32'(IR_Valid), 1);
        chk("mr_refill_pc", 32'(IR_PC), 0);
      end
      next_cycle();
    end
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
